// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bus for serial_subtractor
interface serial_subtractor_if #(parameter int width = 8);
  logic start;
  logic bin;
  logic busy;
  logic done;
  logic bout;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic [width-1:0] diff;
  modport master(output start, a, b, bin, input busy, done, diff, bout);
  modport slave(input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one borrow flip-flop, start/done handshake
module serial_subtractor #(parameter int width = 8) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int cw = (width > 1) ? $clog2(width) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [width-1:0] a_sh, b_sh, work, work_nx, diff_q;
  logic [cw-1:0] cnt;
  logic borrow, bout_q, busy_q, done_q, x, y, d, bn, last;
  always_comb begin
    x = a_sh[0];
    y = b_sh[0];
    d = x ^ y ^ borrow;
    bn = (~x & y) | (~(x ^ y) & borrow);
    work_nx = (work >> 1) | (width'(d) << (width - 1));
    last = cnt == cw'(width - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      work <= '0;
      diff_q <= '0;
      cnt <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        work <= work_nx;
        borrow <= bn;
        cnt <= cnt + cw'(1);
        if (last) begin
          diff_q <= work_nx;
          bout_q <= bn;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state <= DONE;
        end
      end else if (bus.start) begin
        // DONE also accepts start so a held start yields one op every width+1 cycles
        a_sh <= bus.a;
        b_sh <= bus.b;
        borrow <= bus.bin;
        cnt <= '0;
        busy_q <= 1'b1;
        state <= SHIFT;
      end else begin
        state <= IDLE;
      end
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at width 8 and width 1
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  serial_subtractor_if #(.width(8)) w8();
  serial_subtractor_if #(.width(1)) w1();
  serial_subtractor #(.width(8)) u8(.clk(clk), .rst_n(rst_n), .bus(w8));
  serial_subtractor #(.width(1)) u1(.clk(clk), .rst_n(rst_n), .bus(w1));
  always #5 clk = ~clk;
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      output logic [7:0] d, output logic bo, output int lat);
    w8.a = a;
    w8.b = b;
    w8.bin = bi;
    w8.start = 1'b1;
    @(posedge clk);
    #1;
    w8.start = 1'b0;
    lat = 0;
    while (w8.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = w8.diff;
    bo = w8.bout;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({w8.busy, w8.done, w8.diff, w8.bout} !== 11'd0) begin
      failures++;
      $display("FAIL reset8: busy=%b done=%b diff=%0d bout=%b, required all 0", w8.busy, w8.done, w8.diff, w8.bout);
    end
    checks++;
    if ({w1.busy, w1.done, w1.diff, w1.bout} !== 4'd0) begin
      failures++;
      $display("FAIL reset1: busy=%b done=%b diff=%0d bout=%b, required all 0", w1.busy, w1.done, w1.diff, w1.bout);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic_timing;
    w8.a = 8'd100;
    w8.b = 8'd37;
    w8.bin = 1'b0;
    w8.start = 1'b1;
    @(posedge clk);
    #1;
    w8.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (w8.busy !== 1'b1 || w8.done !== 1'b0) begin
        failures++;
        $display("FAIL busy_phase E%0d: busy=%b done=%b, required busy=1 done=0", k, w8.busy, w8.done);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (w8.done !== 1'b1 || w8.busy !== 1'b0 || w8.diff !== 8'd63 || w8.bout !== 1'b0) begin
      failures++;
      $display("FAIL done_E8: done=%b busy=%b diff=%0d bout=%b, required 1 0 63 0", w8.done, w8.busy, w8.diff, w8.bout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (w8.done !== 1'b0 || w8.busy !== 1'b0 || w8.diff !== 8'd63) begin
      failures++;
      $display("FAIL after_E9: done=%b busy=%b diff=%0d, required 0 0 63", w8.done, w8.busy, w8.diff);
    end
  endtask
  task automatic test_vectors;
    logic [7:0] va [3] = '{8'd5, 8'd0, 8'd255};
    logic [7:0] vb [3] = '{8'd10, 8'd0, 8'd255};
    logic vi [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] ed [3] = '{8'd251, 8'd255, 8'd0};
    logic eb [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] d;
    logic bo;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run8(va[i], vb[i], vi[i], d, bo, lat);
      checks++;
      if (d !== ed[i] || bo !== eb[i] || lat != 8) begin
        failures++;
        $display("FAIL vector%0d: diff=%0d bout=%b lat=%0d, required %0d %b 8", i, d, bo, lat, ed[i], eb[i]);
      end
    end
  endtask
  task automatic test_ignore_start;
    int dones = 0;
    w8.a = 8'd100;
    w8.b = 8'd37;
    w8.bin = 1'b0;
    w8.start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      w8.start = (k == 2);
      if (k == 2) begin
        w8.a = 8'd1;
        w8.b = 8'd2;
        w8.bin = 1'b1;
      end
      if (w8.done === 1'b1) begin
        dones++;
        checks++;
        if (w8.diff !== 8'd63 || w8.bout !== 1'b0 || k != 8) begin
          failures++;
          $display("FAIL ignore_result: diff=%0d bout=%b at E%0d, required 63 0 at E8", w8.diff, w8.bout, k);
        end
      end
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL ignore_done_count: %0d pulses, required 1", dones);
    end
  endtask
  task automatic test_reset_abort;
    logic [7:0] d;
    logic bo;
    int lat;
    int dones = 0;
    run8(8'd0, 8'd0, 1'b1, d, bo, lat);
    checks++;
    if (d !== 8'd255 || bo !== 1'b1) begin
      failures++;
      $display("FAIL abort_setup: diff=%0d bout=%b, required 255 1", d, bo);
    end
    w8.a = 8'd100;
    w8.b = 8'd37;
    w8.bin = 1'b0;
    w8.start = 1'b1;
    @(posedge clk);
    #1;
    w8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w8.busy !== 1'b0 || w8.done !== 1'b0 || w8.diff !== 8'd0 || w8.bout !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear: busy=%b done=%b diff=%0d bout=%b, required all 0", w8.busy, w8.done, w8.diff, w8.bout);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (w8.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d pulses, required 0", dones);
    end
    run8(8'd200, 8'd1, 1'b0, d, bo, lat);
    checks++;
    if (d !== 8'd199 || bo !== 1'b0 || lat != 8) begin
      failures++;
      $display("FAIL abort_recover: diff=%0d bout=%b lat=%0d, required 199 0 8", d, bo, lat);
    end
  endtask
  task automatic test_back_to_back;
    logic exp;
    w8.a = 8'd10;
    w8.b = 8'd3;
    w8.bin = 1'b0;
    w8.start = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      @(posedge clk);
      #1;
      exp = (k == 8 || k == 17 || k == 26);
      checks++;
      if (w8.done !== exp || (w8.done === 1'b1 && w8.busy === 1'b1)) begin
        failures++;
        $display("FAIL b2b_done E%0d: done=%b busy=%b, required done=%b busy=0 when done", k, w8.done, w8.busy, exp);
      end
      if (exp) begin
        checks++;
        if (w8.diff !== 8'd7 || w8.bout !== 1'b0) begin
          failures++;
          $display("FAIL b2b_result E%0d: diff=%0d bout=%b, required 7 0", k, w8.diff, w8.bout);
        end
      end
    end
    w8.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_width1;
    logic a1, b1, i1;
    logic [1:0] r;
    int lat;
    for (int n = 0; n <= 1000; n++) begin
      a1 = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      b1 = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      i1 = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      r = {1'b0, a1} - {1'b0, b1} - {1'b0, i1};
      w1.a = a1;
      w1.b = b1;
      w1.bin = i1;
      w1.start = 1'b1;
      @(posedge clk);
      #1;
      w1.start = 1'b0;
      lat = 0;
      while (w1.done !== 1'b1 && lat < 5) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if (w1.diff !== r[0] || w1.bout !== r[1] || lat != 1) begin
        failures++;
        $display("FAIL width1 #%0d a=%b b=%b bin=%b: diff=%b bout=%b lat=%0d, required %b %b 1", n, a1, b1, i1, w1.diff, w1.bout, lat, r[0], r[1]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    w8.start = 1'b0;
    w8.a = '0;
    w8.b = '0;
    w8.bin = 1'b0;
    w1.start = 1'b0;
    w1.a = '0;
    w1.b = '0;
    w1.bin = 1'b0;
    test_reset();
    test_basic_timing();
    test_vectors();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
